// File: rtl/reg_file.sv
// Two-read, one-write register file with x0 hardwired to zero and asynchronous clear.
// Optional write-through forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ADDR_WIDTH-1:0] R1,
    input  logic [ADDR_WIDTH-1:0] R2,
    input  logic [ADDR_WIDTH-1:0] RD,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  reg_write_enable,
    output logic [DATA_WIDTH-1:0] R1_data,
    output logic [DATA_WIDTH-1:0] R2_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_store
                logic [DATA_WIDTH-1:0] reg_q;
                logic [DATA_WIDTH-1:0] reg_d;

                always_comb begin
                    reg_d = reg_q;
                    if (reg_write_enable && (RD == ADDR_WIDTH'(gi))) begin
                        reg_d = RD_DATA;
                    end
                end

                always_ff @(posedge CLK or negedge RST_N) begin
                    if (!RST_N) begin
                        reg_q <= '0;
                    end else begin
                        reg_q <= reg_d;
                    end
                end

                assign regs[gi] = reg_q;
            end
        end
    endgenerate

    always_comb begin
        R1_data = regs[R1];
        R2_data = regs[R2];
`ifdef REG_FILE_BYPASS_EN
        // Forward the in-flight write; never for x0 and never while held in reset.
        if (RST_N && reg_write_enable && (RD != '0)) begin
            if (RD == R1) begin
                R1_data = RD_DATA;
            end
            if (RD == R2) begin
                R2_data = RD_DATA;
            end
        end
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: table-driven write/read vectors with a scoreboard
// queue, plus hand-written reset sequences.
module tb_reg_file;

    logic        CLK;
    logic        RST_N;
    logic [4:0]  R1;
    logic [4:0]  R2;
    logic [4:0]  RD;
    logic [31:0] RD_DATA;
    logic        reg_write_enable;
    logic [31:0] R1_data;
    logic [31:0] R2_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [32];

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] post1;
        logic [31:0] post2;
    } vec_t;
    vec_t vec [10];

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .R1               (R1),
        .R2               (R2),
        .RD               (RD),
        .RD_DATA          (RD_DATA),
        .reg_write_enable (reg_write_enable),
        .R1_data          (R1_data),
        .R2_data          (R2_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected combinational read of idx given the inputs currently driven.
    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        logic [31:0] v;
        v = model[idx];
`ifdef REG_FILE_BYPASS_EN
        if (RST_N && reg_write_enable && RD != 5'd0 && RD == idx) v = RD_DATA;
`endif
        if (!RST_N || idx == 5'd0) v = 32'd0;
        return v;
    endfunction

    task automatic expect_push(input string name, input logic [31:0] e1, input logic [31:0] e2);
        sb_t s;
        s.name = name;
        s.e1   = e1;
        s.e2   = e2;
        sb.push_back(s);
    endtask

    task automatic pop_check();
        sb_t s;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        s = sb.pop_front();
        check({s.name, "_r1"}, R1_data, s.e1);
        check({s.name, "_r2"}, R2_data, s.e2);
        $display("txn %s: R1=%0d R2=%0d R1_data=%h R2_data=%h", s.name, R1, R2, R1_data, R2_data);
    endtask

    initial begin
        RST_N = 1'b0;
        R1 = 5'd1;
        R2 = 5'd2;
        RD = 5'd0;
        RD_DATA = 32'd0;
        reg_write_enable = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        vec[0] = '{1'b1, 5'd1,  32'd5,          5'd1,  5'd0,  32'd5,          32'd0};
        vec[1] = '{1'b1, 5'd2,  32'd10,         5'd1,  5'd2,  32'd5,          32'd10};
        vec[2] = '{1'b0, 5'd2,  32'd99,         5'd1,  5'd2,  32'd5,          32'd10};
        vec[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF,  5'd0,  5'd0,  32'd0,          32'd0};
        vec[4] = '{1'b0, 5'd3,  32'd7,          5'd3,  5'd3,  32'd0,          32'd0};
        vec[5] = '{1'b1, 5'd4,  32'd9,          5'd4,  5'd4,  32'd9,          32'd9};
        vec[6] = '{1'b1, 5'd31, 32'hA5A5_A5A5,  5'd31, 5'd1,  32'hA5A5_A5A5,  32'd5};
        vec[7] = '{1'b1, 5'd1,  32'h1234_5678,  5'd1,  5'd31, 32'h1234_5678,  32'hA5A5_A5A5};
        vec[8] = '{1'b1, 5'd16, 32'hDEAD_BEEF,  5'd16, 5'd4,  32'hDEAD_BEEF,  32'd9};
        vec[9] = '{1'b0, 5'd16, 32'd0,          5'd16, 5'd2,  32'hDEAD_BEEF,  32'd10};

        // Held in reset with a write pending: outputs read zero and the write is lost.
        reg_write_enable = 1'b1;
        RD = 5'd1;
        RD_DATA = 32'h1111_1111;
        #2;
        expect_push("in_reset", 32'd0, 32'd0);
        pop_check();
        @(posedge CLK);
        #1;
        expect_push("in_reset_edge", 32'd0, 32'd0);
        pop_check();

        @(negedge CLK);
        reg_write_enable = 1'b0;
        RST_N = 1'b1;
        for (int i = 0; i < 32; i += 2) begin
            R1 = 5'(i);
            R2 = 5'(i + 1);
            #1;
            check($sformatf("post_reset_x%0d", i), R1_data, 32'd0);
            check($sformatf("post_reset_x%0d", i + 1), R2_data, 32'd0);
        end

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            reg_write_enable = vec[i].we;
            RD = vec[i].rd;
            RD_DATA = vec[i].data;
            R1 = vec[i].r1;
            R2 = vec[i].r2;
            expect_push($sformatf("vec%0d_pre", i), exp_read(vec[i].r1), exp_read(vec[i].r2));
            #1;
            pop_check();
            expect_push($sformatf("vec%0d_post", i), vec[i].post1, vec[i].post2);
            @(posedge CLK);
            if (vec[i].we && vec[i].rd != 5'd0) model[vec[i].rd] = vec[i].data;
            #1;
            pop_check();
        end

        // Asynchronous clear between edges, with a write requested during reset.
        @(negedge CLK);
        reg_write_enable = 1'b1;
        RD = 5'd5;
        RD_DATA = 32'h5555_5555;
        R1 = 5'd1;
        R2 = 5'd5;
        RST_N = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #1;
        expect_push("async_clear", 32'd0, 32'd0);
        pop_check();
        @(posedge CLK);
        #1;
        expect_push("reset_wins", 32'd0, 32'd0);
        pop_check();

        @(negedge CLK);
        RST_N = 1'b1;
        reg_write_enable = 1'b0;
        R1 = 5'd5;
        R2 = 5'd16;
        #1;
        expect_push("after_release", 32'd0, 32'd0);
        pop_check();

        // First write after release lands on the first rising edge.
        @(negedge CLK);
        reg_write_enable = 1'b1;
        RD = 5'd7;
        RD_DATA = 32'h0000_0777;
        R1 = 5'd7;
        R2 = 5'd0;
        expect_push("first_write_pre", exp_read(5'd7), 32'd0);
        #1;
        pop_check();
        @(posedge CLK);
        model[7] = 32'h0000_0777;
        #1;
        expect_push("first_write_post", 32'h0000_0777, 32'd0);
        pop_check();
        @(negedge CLK);
        reg_write_enable = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the register and data-port width.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the register-index width; depth = 2**ADDR_WIDTH (32 registers, x0..x31).
REQ-003 Port CLK, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port RST_N, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port R1, input, ADDR_WIDTH bits, SHALL be the read-port-1 register index.
REQ-006 Port R2, input, ADDR_WIDTH bits, SHALL be the read-port-2 register index.
REQ-007 Port RD, input, ADDR_WIDTH bits, SHALL be the write-port destination register index.
REQ-008 Port RD_DATA, input, DATA_WIDTH bits, SHALL be the write data.
REQ-009 Port reg_write_enable, input, 1 bit, SHALL qualify the write (1 = write).
REQ-010 Port R1_data, output, DATA_WIDTH bits, SHALL be the read data for R1.
REQ-011 Port R2_data, output, DATA_WIDTH bits, SHALL be the read data for R2.

Function
REQ-012 Storage SHALL be 2**ADDR_WIDTH registers of DATA_WIDTH bits; register 0 SHALL always read 0.
REQ-013 Reads SHALL be combinational: R1_data = reg[R1], R2_data = reg[R2], with zero-cycle latency from any index or register change.
REQ-014 On CLK rising edge with RST_N=1 and reg_write_enable=1, reg[RD] SHALL be loaded with RD_DATA; visible on reads after that edge.
REQ-015 Writes with RD=0 SHALL be discarded; R1=0 or R2=0 SHALL return 0 at all times, including the cycle after such a write.
REQ-016 With reg_write_enable=0, no register SHALL change; RD and RD_DATA are don't-care.
REQ-017 R1 and R2 MAY be equal; both ports SHALL return the same value.
REQ-018 With the Configuration macro undefined, a read of the register being written in the same cycle SHALL return the old value until the edge.
REQ-019 Exactly one write per cycle; no write-port arbitration or handshake exists; outputs carry no valid flag.
REQ-020 X/Z on R1/R2 SHALL not corrupt stored state.

Reset
REQ-021 RST_N=0 SHALL asynchronously clear all registers to 0 regardless of CLK; R1_data/R2_data SHALL read 0 while in reset.
REQ-022 A write coinciding with RST_N=0 SHALL be ignored; reset SHALL win.
REQ-023 Release of RST_N SHALL take effect without glitching stored values; first write occurs on the first rising CLK edge with RST_N=1.

Configuration
REQ-024 Macro REG_FILE_BYPASS_EN, when defined, SHALL enable write-through forwarding: if reg_write_enable=1 and RD!=0 and RD equals R1 (resp. R2), R1_data (resp. R2_data) SHALL combinationally show RD_DATA in the same cycle.
REQ-025 When REG_FILE_BYPASS_EN is undefined, no forwarding logic SHALL exist and REQ-018 applies.
REQ-026 Forwarding SHALL never apply to index 0 and SHALL be suppressed while RST_N=0.

Verification
REQ-027 Reset: RST_N=0, R1=1,R2=2 -> R1_data=0, R2_data=0; after release, all 32 registers read 0.
REQ-028 Write/read: write RD=1, RD_DATA=5, enable=1, one edge -> R1=1 gives R1_data=5.
REQ-029 Back-to-back: next cycle write RD=2, RD_DATA=10 with R1=1 -> R1_data=5; then enable=0, R1=1,R2=2 -> R1_data=5, R2_data=10.
REQ-030 x0: write RD=0, RD_DATA=32'hFFFF_FFFF, enable=1 -> R1=0 reads 0.
REQ-031 Enable low: RD=3, RD_DATA=7, enable=0, edge -> R2=3 reads 0.
REQ-032 Bypass: RD=4, RD_DATA=9, enable=1, R1=4 before edge -> R1_data=9 with REG_FILE_BYPASS_EN, 0 without; both read 9 after edge.
